pattern_ram_scheduler: RTL

//  Owns the single-port 72-bit pattern RAM behind stored_pattern playback. Fetches one

---
 rtl/pattern_ram_scheduler_if.sv | 25 ++
 rtl/pattern_ram_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pattern_ram_scheduler_if.sv
// Pattern RAM port and UART upload write channel shared by the playback scheduler.
// The scheduler side is the slave; the uploader plus RAM environment is the master.
interface pattern_ram_scheduler_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 72
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    output wr_req, wr_addr, wr_data, ram_dout,
    input  wr_ack, ram_addr, ram_we, ram_din
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, ram_dout,
    output wr_ack, ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/pattern_ram_scheduler.sv
// Single-port pattern RAM owner: steps a [start,end] frame loop every HOLD ticks and
// slots upload writes between playback fetches so a write never lands mid-read.
module pattern_ram_scheduler #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 72
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  input  logic [3:0]            hold,
  pattern_ram_scheduler_if.slave bus,
  output logic [DATA_W-1:0]     frame,
  output logic [ADDR_W-1:0]     frame_addr,
  output logic                  frame_valid,
  output logic                  loop_done,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] play_addr_r;
  logic [ADDR_W-1:0] loop_end_r;
  logic [3:0]        hold_cnt_r;
  logic [3:0]        hold_last_s;
  logic              fetch_pend_r;
  logic              step_due_s;
  logic              at_end_s;
  logic [DATA_W-1:0] frame_r;
  logic [ADDR_W-1:0] frame_addr_r;
  logic              frame_valid_r;
  logic              loop_done_r;
  logic              overrun_r;

  // Step qualification; a count left above a freshly lowered hold also forces a step
  always_comb begin
    hold_last_s = 4'd0;
    step_due_s  = 1'b0;
    at_end_s    = (play_addr_r == loop_end_r);
    if (hold == 4'd0) begin
      hold_last_s = 4'd0;
    end else begin
      hold_last_s = hold - 4'd1;
    end
    if (enable && tick) begin
      step_due_s = (hold_cnt_r >= hold_last_s);
    end else begin
      step_due_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: a pending fetch always beats an upload
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (fetch_pend_r && enable) begin
          state_next_s = ST_READ;
        end else if (bus.wr_req) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ:    state_next_s = ST_CAPTURE;
      ST_CAPTURE: state_next_s = ST_IDLE;
      ST_WRITE:   state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: RAM port and write acknowledge decoded from state
  always_comb begin
    bus.ram_addr = play_addr_r;
    bus.ram_we   = 1'b0;
    bus.ram_din  = {DATA_W{1'b0}};
    bus.wr_ack   = 1'b0;
    case (state_r)
      ST_WRITE: begin
        bus.ram_addr = bus.wr_addr;
        bus.ram_we   = 1'b1;
        bus.ram_din  = bus.wr_data;
        bus.wr_ack   = 1'b1;
      end
      default: begin
        bus.ram_addr = play_addr_r;
      end
    endcase
  end

  // Playback pointer, hold counter and fetch request; loop end is re-latched only at wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      play_addr_r  <= {ADDR_W{1'b0}};
      loop_end_r   <= {ADDR_W{1'b0}};
      hold_cnt_r   <= 4'd0;
      fetch_pend_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      overrun_r <= step_due_s && fetch_pend_r && (state_r != ST_READ);
      if (!enable) begin
        play_addr_r  <= start_addr;
        loop_end_r   <= end_addr;
        hold_cnt_r   <= 4'd0;
        fetch_pend_r <= 1'b0;
      end else begin
        if (tick) begin
          hold_cnt_r <= step_due_s ? 4'd0 : hold_cnt_r + 4'd1;
        end
        if (step_due_s) begin
          fetch_pend_r <= 1'b1;
        end else if (state_r == ST_READ) begin
          fetch_pend_r <= 1'b0;
        end
        if (state_r == ST_CAPTURE) begin
          if (at_end_s) begin
            play_addr_r <= start_addr;
            loop_end_r  <= end_addr;
          end else begin
            play_addr_r <= play_addr_r + ADDR_W'(1);
          end
        end
      end
    end
  end

  // Captured frame and loop-completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_r       <= {DATA_W{1'b0}};
      frame_addr_r  <= {ADDR_W{1'b0}};
      frame_valid_r <= 1'b0;
      loop_done_r   <= 1'b0;
    end else begin
      loop_done_r <= 1'b0;
      if (state_r == ST_CAPTURE) begin
        frame_r       <= bus.ram_dout;
        frame_addr_r  <= play_addr_r;
        frame_valid_r <= 1'b1;
        loop_done_r   <= at_end_s;
      end
    end
  end

  assign frame       = frame_r;
  assign frame_addr  = frame_addr_r;
  assign frame_valid = frame_valid_r;
  assign loop_done   = loop_done_r;
  assign overrun     = overrun_r;

endmodule
